// File: rtl/dds_wavegen.sv
// DDS engine: phase accumulator, phase offset, quarter-wave sine table, sine/square/saw/triangle select.
// Define DDS_AMP_SCALE_EN to add the amp_in port and an amplitude-scaling fourth stage.
module dds_wavegen #(
  parameter int                 PHASE_W   = 32,
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 12,
  parameter logic [PHASE_W-1:0] FTW_RESET = 32'h0040_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] pow_in,
  input  logic [1:0]         mode,
`ifdef DDS_AMP_SCALE_EN
  input  logic [DATA_W-1:0]  amp_in,
`endif
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_wrap
);

  localparam int QDEPTH = 2 ** (ADDR_W - 2);
  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] FULL = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  // Quarter-wave entry round((2^(DATA_W-1)-1)*sin(pi*(2k+1)/2^ADDR_W)), Q30 Taylor series at elaboration.
  function automatic logic [DATA_W-2:0] lut_entry(input int k);
    longint x, x2, term, sum, amp;
    x    = (64'sd3373259426 * longint'(2 * k + 1)) >>> ADDR_W;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (DATA_W - 1)) - 1;
    return (DATA_W-1)'((amp * sum + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [DATA_W-2:0] lut [QDEPTH];
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_lut
    localparam logic [DATA_W-2:0] ENTRY = lut_entry(gi);
    assign lut[gi] = ENTRY;
  end

  // Accumulator and tuning-word handshake
  logic [PHASE_W-1:0] acc, ftw_active, ftw_pend;
  logic               pending, acc_wrap;
  logic [PHASE_W:0]   acc_sum;
  logic               wrap_now, ftw_take;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_active};
  assign wrap_now  = en & acc_sum[PHASE_W];
  assign ftw_take  = ftw_valid & ~pending;
  assign ftw_ready = ~pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      acc_wrap   <= 1'b0;
      ftw_active <= FTW_RESET;
      pending    <= 1'b0;
    end else begin
      if (en) begin
        acc      <= acc_sum[PHASE_W-1:0];
        acc_wrap <= acc_sum[PHASE_W];
      end
      if (pending && (wrap_now || !en)) begin
        ftw_active <= ftw_pend;
        pending    <= 1'b0;
      end else if (ftw_take) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ftw_take) ftw_pend <= ftw_in;
  end

  // Stage 1: offset phase, with mode and wrap flag travelling beside it
  logic [PHASE_W-1:0] ph_p1;
  logic [1:0]         mode_p1;
  logic               wrap_p1, vld_p1;
  logic               unused_ph;

  assign unused_ph = ^ph_p1;

  always_ff @(posedge clk) begin
    ph_p1   <= acc + pow_in;
    mode_p1 <= mode;
    wrap_p1 <= acc_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= en;
  end

  // Stage 2: table read with quadrant mirroring; non-sine waves formed here
  logic [1:0]        quad;
  logic [ADDR_W-3:0] k_idx, rd_idx;
  logic [DATA_W-1:0] tri_t, alt_s;
  logic [DATA_W-2:0] mag_p2;
  logic [DATA_W-1:0] alt_p2;
  logic [1:0]        mode_p2;
  logic              neg_p2, wrap_p2, vld_p2;

  assign quad   = ph_p1[PHASE_W-1 -: 2];
  assign k_idx  = ph_p1[PHASE_W-3 -: ADDR_W-2];
  assign rd_idx = quad[0] ? ~k_idx : k_idx;
  assign tri_t  = ph_p1[PHASE_W-2 -: DATA_W];

  always_comb begin
    alt_s = '0;
    case (mode_p1)
      2'b01:   alt_s = ph_p1[PHASE_W-1] ? ONE : FULL;
      2'b10:   alt_s = ph_p1[PHASE_W-1 -: DATA_W];
      2'b11:   alt_s = ph_p1[PHASE_W-1] ? ~tri_t : tri_t;
      default: alt_s = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    mag_p2  <= lut[rd_idx];
    neg_p2  <= quad[1];
    alt_p2  <= alt_s;
    mode_p2 <= mode_p1;
    wrap_p2 <= wrap_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  // Stage 3: sign the sine magnitude around MID and select the output wave
  logic [DATA_W-1:0] sine_s, samp_p3;
  logic              vld_p3, wrap_p3;

  assign sine_s = neg_p2 ? (MID - {1'b0, mag_p2}) : (MID + {1'b0, mag_p2});

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_p3 <= MID;
      vld_p3  <= 1'b0;
      wrap_p3 <= 1'b0;
    end else begin
      vld_p3  <= vld_p2;
      wrap_p3 <= vld_p2 & wrap_p2;
      if (vld_p2) samp_p3 <= (mode_p2 == 2'b00) ? sine_s : alt_p2;
    end
  end

`ifdef DDS_AMP_SCALE_EN
  localparam int PW = 2 * DATA_W + 2;
  localparam logic signed [PW-1:0] FULL_X = PW'(FULL);

  function automatic logic [DATA_W-1:0] sat_sample(input logic signed [PW-1:0] v);
    if (v < 1)           return ONE;
    else if (v > FULL_X) return FULL;
    else                 return v[DATA_W-1:0];
  endfunction

  // Stage 4: scale deviation from MID by amp_in (unity = 2^(DATA_W-1)) and clamp
  logic signed [DATA_W:0] dev_s;
  logic signed [PW-1:0]   prod_s, scaled_s;
  logic [DATA_W-1:0]      samp_p4;
  logic                   vld_p4, wrap_p4;

  assign dev_s    = $signed({1'b0, samp_p3}) - $signed({1'b0, MID});
  assign prod_s   = dev_s * $signed({1'b0, amp_in});
  assign scaled_s = (prod_s >>> (DATA_W - 1)) + $signed(PW'(MID));

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_p4 <= MID;
      vld_p4  <= 1'b0;
      wrap_p4 <= 1'b0;
    end else begin
      vld_p4  <= vld_p3;
      wrap_p4 <= vld_p3 & wrap_p3;
      if (vld_p3) samp_p4 <= sat_sample(scaled_s);
    end
  end

  assign out_data  = samp_p4;
  assign out_valid = vld_p4;
  assign out_wrap  = wrap_p4;
`else
  assign out_data  = samp_p3;
  assign out_valid = vld_p3;
  assign out_wrap  = wrap_p3;
`endif

endmodule
